// File: rtl/mem_stage_if.sv
// mem_stage_if: data-bus request/response handshake between the memory stage and the bus.
interface mem_stage_if #(parameter int ADDR_W = 64, parameter int DATA_W = 64);
  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  logic [1:0]        dreq_size;
  logic [DATA_W/8-1:0] dreq_strobe;
  logic [DATA_W-1:0] dreq_data;
  logic              dresp_data_ok;
  logic [DATA_W-1:0] dresp_data;
  modport master(output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
                 input dresp_data_ok, dresp_data);
  modport slave(input dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
                output dresp_data_ok, dresp_data);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage; issues bus requests, aligns store/load data, stalls until the bus completes.
module mem_stage #(parameter int ADDR_W = 64, parameter int DATA_W = 64) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [63:0]       in_pc,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [1:0]        in_mem_size,
  input  logic              in_mem_unsigned,
  input  logic              in_regwrite,
  input  logic [4:0]        in_dst,
  input  logic              flush,
  mem_stage_if.master       dbus,
  output logic              stall,
  output logic              out_valid,
  output logic [63:0]       out_pc,
  output logic [4:0]        out_dst,
  output logic              out_regwrite,
  output logic [DATA_W-1:0] out_result,
  output logic              out_misalign
);
  localparam int SW = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state;
  logic [ADDR_W-1:0] addrQ;
  logic [1:0]        sizeQ;
  logic [SW-1:0]     strobeQ, sizeMask;
  logic [DATA_W-1:0] dataQ, loadQ, shifted, loadExt;
  logic [2:0]        off, offQ;
  logic              unsQ, drop, memOp, misaligned, go;
  assign off = in_alu_out[2:0];
  assign memOp = in_valid & (in_mem_read | in_mem_write);
  assign misaligned = memOp & ((in_mem_size == 2'd1 & off[0]) | (in_mem_size == 2'd2 & off[1:0] != 2'd0) |
                               (in_mem_size == 2'd3 & off != 3'd0));
  assign go = state == IDLE & memOp & ~misaligned & ~flush;
  assign sizeMask = in_mem_size == 2'd0 ? SW'(8'h01) : in_mem_size == 2'd1 ? SW'(8'h03) :
                    in_mem_size == 2'd2 ? SW'(8'h0F) : {SW{1'b1}};
  // Loads are extracted from the raw beat using the offset captured at request time
  assign shifted = dbus.dresp_data >> {offQ, 3'b000};
  assign loadExt = sizeQ == 2'd0 ? {{(DATA_W-8){~unsQ & shifted[7]}}, shifted[7:0]} :
                   sizeQ == 2'd1 ? {{(DATA_W-16){~unsQ & shifted[15]}}, shifted[15:0]} :
                   sizeQ == 2'd2 ? {{(DATA_W-32){~unsQ & shifted[31]}}, shifted[31:0]} : shifted;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      addrQ <= '0;
      sizeQ <= '0;
      strobeQ <= '0;
      dataQ <= '0;
      loadQ <= '0;
      offQ <= '0;
      unsQ <= 1'b0;
      drop <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (go) begin
            addrQ <= in_alu_out[ADDR_W-1:0];
            sizeQ <= in_mem_size;
            strobeQ <= in_mem_write ? sizeMask << off : '0;
            dataQ <= in_wdata << {off, 3'b000};
            offQ <= off;
            unsQ <= in_mem_unsigned;
            state <= REQ;
          end
        end
        REQ: begin
          if (flush) drop <= 1'b1;
          if (dbus.dresp_data_ok) begin
            loadQ <= loadExt;
            state <= DONE;
          end
        end
        DONE: begin
          drop <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign dbus.dreq_valid = state == REQ;
  assign dbus.dreq_addr = addrQ;
  assign dbus.dreq_size = sizeQ;
  assign dbus.dreq_strobe = strobeQ;
  assign dbus.dreq_data = dataQ;
  assign stall = state == REQ | go;
  assign out_valid = state == IDLE ? in_valid & ~flush & (~memOp | misaligned) : state == DONE & ~drop;
  assign out_misalign = state == IDLE & misaligned & ~flush;
  assign out_regwrite = in_regwrite & ~misaligned;
  assign out_result = state == DONE & in_mem_read ? loadQ : in_alu_out;
  assign out_pc = in_pc;
  assign out_dst = in_dst;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a byte-lane reference model.
module tb_mem_stage;
  logic clk = 1'b0, reset;
  logic in_valid, in_mem_read, in_mem_write, in_mem_unsigned, in_regwrite, flush;
  logic [63:0] in_pc, in_alu_out, in_wdata;
  logic [1:0] in_mem_size;
  logic [4:0] in_dst;
  logic stall, out_valid, out_regwrite, out_misalign;
  logic [63:0] out_pc, out_result;
  logic [4:0] out_dst;
  int total = 0, passed = 0, failed = 0;

  mem_stage_if #(.ADDR_W(64), .DATA_W(64)) dbus();
  mem_stage #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_alu_out(in_alu_out),
    .in_wdata(in_wdata), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_mem_size(in_mem_size), .in_mem_unsigned(in_mem_unsigned), .in_regwrite(in_regwrite),
    .in_dst(in_dst), .flush(flush), .dbus(dbus), .stall(stall), .out_valid(out_valid),
    .out_pc(out_pc), .out_dst(out_dst), .out_regwrite(out_regwrite), .out_result(out_result),
    .out_misalign(out_misalign));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] loadModel(input logic [63:0] raw, input int off, input int n, input bit uns);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = raw[8*(off+i) +: 8];
    if (!uns && n < 8 && v[8*n-1]) for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] stbModel(input int off, input int n, input bit wr);
    logic [7:0] s = '0;
    for (int i = 0; i < 8; i++) s[i] = wr && i >= off && i < off + n;
    return s;
  endfunction

  function automatic logic [63:0] dataModel(input logic [63:0] w, input int off);
    logic [63:0] d = '0;
    for (int i = off; i < 8; i++) d[8*i +: 8] = w[8*(i-off) +: 8];
    return d;
  endfunction

  task automatic setIdle();
    in_valid = 0; in_mem_read = 0; in_mem_write = 0; in_mem_size = 0; in_mem_unsigned = 0;
    in_regwrite = 0; in_dst = 0; in_pc = 0; in_alu_out = 0; in_wdata = 0; flush = 0;
    dbus.dresp_data_ok = 0; dbus.dresp_data = 0;
  endtask

  task automatic setMem(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [63:0] addr, input logic [63:0] wd);
    in_valid = 1; in_mem_read = rd; in_mem_write = wr; in_mem_size = sz; in_mem_unsigned = uns;
    in_alu_out = addr; in_wdata = wd; in_regwrite = rd; in_dst = 5'($urandom); in_pc = {$urandom, $urandom};
    flush = 0;
  endtask

  // Called just after a negedge with an aligned memory op on the inputs; data_ok arrives on REQ cycle lat.
  task automatic runMem(input int lat, input int flushAt, input logic [63:0] rdata, input logic [63:0] expRes);
    int off = int'(in_alu_out[2:0]);
    int n = 1 << in_mem_size;
    logic [7:0] expStb = stbModel(off, n, in_mem_write);
    logic [63:0] expData = dataModel(in_wdata, off);
    bit dropped = 0;
    #1;
    chkb("accept_stall", stall, 1'b1);
    chkb("accept_out_valid", out_valid, 1'b0);
    chkb("accept_dreq_valid", dbus.dreq_valid, 1'b0);
    @(negedge clk);
    for (int k = 1; k <= lat; k++) begin
      flush = (k == flushAt);
      if (k == flushAt) dropped = 1;
      dbus.dresp_data_ok = (k == lat);
      dbus.dresp_data = (k == lat) ? rdata : {$urandom, $urandom};
      #1;
      chkb("req_valid", dbus.dreq_valid, 1'b1);
      chk("req_addr", dbus.dreq_addr, in_alu_out);
      chk("req_size", 64'(dbus.dreq_size), 64'(in_mem_size));
      chk("req_strobe", 64'(dbus.dreq_strobe), 64'(expStb));
      if (in_mem_write) chk("req_data", dbus.dreq_data, expData);
      chkb("req_stall", stall, 1'b1);
      chkb("req_out_valid", out_valid, 1'b0);
      @(negedge clk);
    end
    flush = 0;
    dbus.dresp_data_ok = 0;
    #1;
    chkb("done_stall", stall, 1'b0);
    chkb("done_dreq_valid", dbus.dreq_valid, 1'b0);
    chkb("done_out_valid", out_valid, !dropped);
    chk("done_result", out_result, expRes);
    @(negedge clk);
    setIdle();
    #1;
    chkb("post_dreq_valid", dbus.dreq_valid, 1'b0);
    chkb("post_out_valid", out_valid, 1'b0);
    chkb("post_stall", stall, 1'b0);
  endtask

  initial begin
    setIdle();
    reset = 1;
    repeat (2) @(negedge clk);
    #1;
    chkb("rst_dreq_valid", dbus.dreq_valid, 1'b0);
    chk("rst_dreq_addr", dbus.dreq_addr, 64'h0);
    chk("rst_dreq_strobe", 64'(dbus.dreq_strobe), 64'h0);
    chk("rst_dreq_data", dbus.dreq_data, 64'h0);
    chkb("rst_stall", stall, 1'b0);
    chkb("rst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    reset = 0;

    // non-memory passthrough; a stray data_ok must be ignored
    @(negedge clk);
    in_valid = 1; in_alu_out = 64'h1234; in_regwrite = 1; in_dst = 5'd7; in_pc = 64'h400;
    dbus.dresp_data_ok = 1;
    #1;
    chkb("pass_valid", out_valid, 1'b1);
    chk("pass_result", out_result, 64'h1234);
    chkb("pass_stall", stall, 1'b0);
    chkb("pass_dreq", dbus.dreq_valid, 1'b0);
    chk("pass_pc", out_pc, 64'h400);
    chk("pass_dst", 64'(out_dst), 64'd7);
    @(negedge clk);
    #1;
    chkb("pass_dreq2", dbus.dreq_valid, 1'b0);
    chkb("pass_valid2", out_valid, 1'b1);
    setIdle();

    @(negedge clk);
    setMem(1, 0, 2'd0, 0, 64'h0000_0000_ABCD_0003, 64'h0);
    runMem(2, 0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    @(negedge clk);
    setMem(1, 0, 2'd0, 1, 64'h0000_0000_ABCD_0003, 64'h0);
    runMem(2, 0, 64'h0000_0000_8000_0000, 64'h80);
    @(negedge clk);
    setMem(0, 1, 2'd1, 0, 64'h0000_0000_0000_1006, 64'hBEEF);
    #1;
    chkb("hs_accept_stall", stall, 1'b1);
    @(negedge clk);
    #1;
    chk("hs_strobe", 64'(dbus.dreq_strobe), 64'hC0);
    chk("hs_data", dbus.dreq_data, 64'hBEEF_0000_0000_0000);
    @(negedge clk);
    dbus.dresp_data_ok = 1;
    #1;
    chk("hs_strobe_hold", 64'(dbus.dreq_strobe), 64'hC0);
    chk("hs_data_hold", dbus.dreq_data, 64'hBEEF_0000_0000_0000);
    @(negedge clk);
    dbus.dresp_data_ok = 0;
    #1;
    chkb("hs_done_valid", out_valid, 1'b1);
    chk("hs_done_result", out_result, 64'h1006);
    @(negedge clk);
    setIdle();

    // misaligned word load
    @(negedge clk);
    setMem(1, 0, 2'd2, 0, 64'h0000_0000_0000_2002, 64'h0);
    #1;
    chkb("mis_misalign", out_misalign, 1'b1);
    chkb("mis_regwrite", out_regwrite, 1'b0);
    chkb("mis_valid", out_valid, 1'b1);
    chkb("mis_stall", stall, 1'b0);
    @(negedge clk);
    #1;
    chkb("mis_dreq", dbus.dreq_valid, 1'b0);
    setIdle();

    // flush while waiting in REQ: data_ok lands four cycles later
    @(negedge clk);
    setMem(1, 0, 2'd3, 0, 64'h0000_0000_0000_3008, 64'h0);
    runMem(5, 1, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788);

    // flush while idle suppresses the request
    @(negedge clk);
    setMem(1, 0, 2'd1, 0, 64'h0000_0000_0000_4004, 64'h0);
    flush = 1;
    #1;
    chkb("iflush_stall", stall, 1'b0);
    chkb("iflush_valid", out_valid, 1'b0);
    @(negedge clk);
    #1;
    chkb("iflush_dreq", dbus.dreq_valid, 1'b0);
    setIdle();

    // asynchronous reset in the middle of a request
    @(negedge clk);
    setMem(1, 0, 2'd3, 0, 64'h0000_0000_0000_5000, 64'h0);
    @(negedge clk);
    #1;
    chkb("rmid_req", dbus.dreq_valid, 1'b1);
    #1;
    reset = 1;
    setIdle();
    #1;
    chkb("rmid_dreq_drop", dbus.dreq_valid, 1'b0);
    chkb("rmid_stall", stall, 1'b0);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chkb("rmid_no_valid", out_valid, 1'b0);
      chkb("rmid_no_dreq", dbus.dreq_valid, 1'b0);
    end
    @(negedge clk);
    setMem(1, 0, 2'd2, 0, 64'h0000_0000_0000_6004, 64'h0);
    runMem(1, 0, 64'hCAFE_F00D_0000_0000, 64'hFFFF_FFFF_CAFE_F00D);

    for (int t = 0; t < 60; t++) begin
      int kind = $urandom_range(0, 2);
      logic [1:0] sz = 2'($urandom);
      int n = 1 << sz;
      logic [63:0] addr = {$urandom, $urandom};
      logic [63:0] wd = {$urandom, $urandom};
      logic [63:0] rdata = {$urandom, $urandom};
      bit uns = 1'($urandom);
      int lat = $urandom_range(1, 4);
      int fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
      if ($urandom_range(0, 3) != 0) addr[2:0] = 3'((int'(addr[2:0]) / n) * n);
      @(negedge clk);
      if (kind == 0) begin
        in_valid = 1; in_alu_out = addr; in_regwrite = 1;
        #1;
        chkb("rnd_pass_valid", out_valid, 1'b1);
        chk("rnd_pass_result", out_result, addr);
        chkb("rnd_pass_stall", stall, 1'b0);
        setIdle();
      end else if (int'(addr[2:0]) % n != 0) begin
        setMem(kind == 1, kind == 2, sz, uns, addr, wd);
        #1;
        chkb("rnd_mis_misalign", out_misalign, 1'b1);
        chkb("rnd_mis_stall", stall, 1'b0);
        chkb("rnd_mis_regwrite", out_regwrite, 1'b0);
        @(negedge clk);
        #1;
        chkb("rnd_mis_dreq", dbus.dreq_valid, 1'b0);
        setIdle();
      end else begin
        setMem(kind == 1, kind == 2, sz, uns, addr, wd);
        runMem(lat, fa, rdata, kind == 1 ? loadModel(rdata, int'(addr[2:0]), n, uns) : addr);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
